// File: rtl/csa19_pkg.sv
// Shared types and constants for the csa19 accumulate stage.
// Optional build macro consumed elsewhere: CSA19_ACCUM_SATURATE_EN.
package csa19_pkg;

    localparam int unsigned CSA19_WIDTH = 19;
    localparam int unsigned CSA19_CNT_W = 8;

    localparam logic [CSA19_WIDTH-1:0] ACC_MAX = {CSA19_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

endpackage

// File: rtl/csa19_burst_counter.sv
// Loadable down-counter tracking operands still owed in a burst.
// Load wins over decrement; decrement saturates at zero.
module csa19_burst_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             dec_i,
    output logic             is_one_o,
    output logic             is_zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = count_i;
        end else if (dec_i && !is_zero_o) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign is_one_o  = (count_q == CNT_W'(1));
    assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/csa19_accum_stage.sv
// Burst sequencer around an external 19-bit carry-select adder.
// Build option: define CSA19_ACCUM_SATURATE_EN to clamp the total at all ones on carry-out.
module csa19_accum_stage
    import csa19_pkg::*;
#(
    parameter int unsigned WIDTH = CSA19_WIDTH,
    parameter int unsigned CNT_W = CSA19_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [WIDTH-1:0] i_op_data,
    output logic [WIDTH-1:0] o_add_term1,
    output logic [WIDTH-1:0] o_add_term2,
    input  logic [WIDTH-1:0] i_sum,
    input  logic             i_cout,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow,
    output logic             o_busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             op_hs;
    logic             start_burst;
    logic             cnt_one, cnt_zero;

    assign op_hs       = (state_q == ACCUM) && i_op_valid;
    assign start_burst = (state_q == IDLE) && i_start;

    csa19_burst_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk_i    (i_clk),
        .rst_ni   (i_rst_n),
        .load_i   (start_burst),
        .count_i  (i_count),
        .dec_i    (op_hs),
        .is_one_o (cnt_one),
        .is_zero_o(cnt_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = (i_count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // cnt_zero only guards against an unreachable empty burst.
                if ((op_hs && cnt_one) || cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_op_ready  = 1'b0;
        o_res_valid = 1'b0;
        o_busy      = 1'b1;
        o_add_term2 = '0;
        unique case (state_q)
            IDLE:  o_busy = 1'b0;
            ACCUM: begin
                o_op_ready  = 1'b1;
                o_add_term2 = i_op_data;
            end
            DONE:  o_res_valid = 1'b1;
            default: o_busy = 1'b0;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (start_burst) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (op_hs) begin
            ovf_d = ovf_q | i_cout;
`ifdef CSA19_ACCUM_SATURATE_EN
            // Once clamped, stay clamped for the rest of the burst.
            acc_d = (i_cout || ovf_q) ? {WIDTH{1'b1}} : i_sum;
`else
            acc_d = i_sum;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_add_term1 = acc_q;
    assign o_result    = acc_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_csa19_accum_stage.sv
// Directed bench for csa19_accum_stage with a behavioural 19-bit adder in the loop.
module tb_csa19_accum_stage;

    localparam int unsigned WIDTH = 19;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [WIDTH-1:0] op_data = '0;
    logic [WIDTH-1:0] add_term1, add_term2, add_sum;
    logic             add_cout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_term1} + {1'b0, add_term2};

    csa19_accum_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_count    (count),
        .i_op_valid (op_valid),
        .o_op_ready (op_ready),
        .i_op_data  (op_data),
        .o_add_term1(add_term1),
        .o_add_term2(add_term2),
        .i_sum      (add_sum),
        .i_cout     (add_cout),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_result   (result),
        .o_overflow (overflow),
        .o_busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic start_burst(input logic [CNT_W-1:0] n);
        start = 1'b1;
        count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] d);
        int n = 0;
        op_valid = 1'b1;
        op_data  = d;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("op_ready_wait", {31'b0, op_ready}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_consume", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ops4 [4];
        int               gaps [4];
        logic [WIDTH-1:0] exp_acc;

        // Reset state
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_op_ready", {31'b0, op_ready}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_term2", 32'(add_term2), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100 + 200 + 300
        start_burst(8'd3);
        check("t1_op_ready", {31'b0, op_ready}, 32'd1);
        check("t1_busy", {31'b0, busy}, 32'd1);
        send_op(19'd100);
        send_op(19'd200);
        send_op(19'd300);
        check("t1_res_valid", {31'b0, res_valid}, 32'd1);
        check("t1_result", 32'(result), 32'd600);
        check("t1_overflow", {31'b0, overflow}, 32'd0);
        consume();

        // Carry-out: 0x7FFFF + 1
        start_burst(8'd2);
        send_op(19'h7FFFF);
        send_op(19'h00001);
        check("t2_res_valid", {31'b0, res_valid}, 32'd1);
`ifdef CSA19_ACCUM_SATURATE_EN
        check("t2_result", 32'(result), 32'h7FFFF);
`else
        check("t2_result", 32'(result), 32'h0);
`endif
        check("t2_overflow", {31'b0, overflow}, 32'd1);
        consume();

        // Empty burst
        start = 1'b1;
        count = 8'd0;
        check("t3_no_ready_pre", {31'b0, op_ready}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("t3_res_valid", {31'b0, res_valid}, 32'd1);
        check("t3_no_ready", {31'b0, op_ready}, 32'd0);
        check("t3_result", 32'(result), 32'd0);
        check("t3_overflow", {31'b0, overflow}, 32'd0);
        consume();

        // 1+2+3+4 with valid gaps; acc must hold on gap cycles
        ops4 = '{19'd1, 19'd2, 19'd3, 19'd4};
        gaps = '{1, 0, 3, 2};
        exp_acc = '0;
        start_burst(8'd4);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                check("t4_gap_acc", 32'(add_term1), 32'(exp_acc));
            end
            send_op(ops4[i]);
            exp_acc = exp_acc + ops4[i];
        end
        check("t4_res_valid", {31'b0, res_valid}, 32'd1);
        check("t4_result", 32'(result), 32'd10);

        // Result backpressure with start pulses that must be ignored
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            count = 8'd5;
            @(negedge clk);
            check("t5_result_hold", 32'(result), 32'd10);
            check("t5_busy", {31'b0, busy}, 32'd1);
            check("t5_valid_hold", {31'b0, res_valid}, 32'd1);
        end
        // Start alongside the consume is not taken; held start lands one cycle later
        start = 1'b1;
        count = 8'd2;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("t5_idle_after_ready", {31'b0, busy}, 32'd0);
        check("t5_valid_drop", {31'b0, res_valid}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("t5_restart_ready", {31'b0, op_ready}, 32'd1);
        send_op(19'd5);
        send_op(19'd6);
        check("t5_restart_result", 32'(result), 32'd11);
        consume();

        // Reset mid-burst
        start_burst(8'd5);
        send_op(19'd1);
        send_op(19'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_op_ready", {31'b0, op_ready}, 32'd0);
        check("t6_rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("t6_rst_result", 32'(result), 32'd0);
        check("t6_rst_overflow", {31'b0, overflow}, 32'd0);
        check("t6_rst_term1", 32'(add_term1), 32'd0);
        check("t6_rst_term2", 32'(add_term2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_burst(8'd1);
        send_op(19'd7);
        check("t6_res_valid", {31'b0, res_valid}, 32'd1);
        check("t6_result", 32'(result), 32'd7);
        check("t6_overflow", {31'b0, overflow}, 32'd0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
